// File: rtl/tap_per_counter_pkg.sv
// Shared tap-tempo definitions: state encoding and the derived period/BPM sizing
// helpers, so the period counter and the downstream divider agree on widths.
package tap_per_counter_pkg;

  localparam longint unsigned MIN_NS = 64'd60_000_000_000;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  function automatic int btn_per_max(input int clk_per_ns, input int tp_cycle);
    longint unsigned v;
    v = (MIN_NS / 64'(clk_per_ns)) / 64'(tp_cycle);
    return int'(v);
  endfunction

  function automatic int btn_per_size(input int clk_per_ns, input int tp_cycle);
    return $clog2(1 + btn_per_max(clk_per_ns, tp_cycle));
  endfunction

  function automatic int btn_per_min(input int clk_per_ns, input int tp_cycle, input int bpm_max);
    return btn_per_max(clk_per_ns, tp_cycle) / bpm_max;
  endfunction

  function automatic int bpm_size(input int bpm_max);
    return $clog2(1 + bpm_max);
  endfunction

endpackage

// File: rtl/timepulse_gen.sv
// Time-pulse prescaler: free-running 0..TP_CYCLE-1 counter, tick on the last
// phase, with a synchronous restart that makes the restart cycle phase 0.
module timepulse_gen #(
  parameter int TP_CYCLE = 5120
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (TP_CYCLE > 1) ? $clog2(TP_CYCLE) : 1;
  localparam logic [CW-1:0] LAST   = CW'(TP_CYCLE - 1);
  localparam logic [CW-1:0] PHASE1 = (TP_CYCLE > 1) ? CW'(1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // The restart cycle counts as phase 0, so the next cycle is already phase 1.
  always_comb begin
    if (restart_i)          cnt_d = PHASE1;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/tap_per_counter.sv
// Tap period counter: measures ticks between debounced rising edges of btn_i.
// Optional 4-period running average is enabled by defining TAP_AVG_EN.
module tap_per_counter
  import tap_per_counter_pkg::*;
#(
  parameter  int CLK_PER_NS   = 40,
  parameter  int TP_CYCLE     = 5120,
  localparam int BTN_PER_MAX  = btn_per_max(CLK_PER_NS, TP_CYCLE),
  localparam int BTN_PER_SIZE = btn_per_size(CLK_PER_NS, TP_CYCLE)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    btn_i,
  output logic [BTN_PER_SIZE-1:0] btn_per_o,
  output logic                    btn_per_valid,
  output logic                    tp_o
);

  localparam int W = BTN_PER_SIZE;
  localparam logic [W-1:0] CNT_TIMEOUT = W'(BTN_PER_MAX);

  logic         btn_q, btn_d;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0] per_q, per_d, emit_val;
  logic         valid_q, valid_d;
  logic         tap, tick, emit, timeout;

  assign tap     = btn_i & ~btn_q;
  assign cnt_inc = cnt_q + W'(1);

  timepulse_gen #(.TP_CYCLE(TP_CYCLE)) u_tp (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .restart_i (tap),
    .tick_o    (tick)
  );

  // A tap in the same cycle as a tick wins; the tick is simply not counted.
  always_comb begin
    btn_d   = btn_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    valid_d = 1'b0;
    emit    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tap) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (tap) begin
          emit    = 1'b1;
          per_d   = emit_val;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == CNT_TIMEOUT) begin
            timeout = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      btn_q   <= btn_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      valid_q <= valid_d;
    end
  end

`ifdef TAP_AVG_EN
  localparam int SW = W + 2;

  logic [W-1:0]  hist_q [4];
  logic [W-1:0]  hist_d [4];
  logic [SW-1:0] sum_q, sum_d, sum_next;
  logic [2:0]    fill_q, fill_d;

  // Unfilled history slots are zero, so dropping hist_q[3] is always safe.
  always_comb begin
    sum_next = sum_q + SW'(cnt_q) - SW'(hist_q[3]);
    emit_val = (fill_q >= 3'd3) ? sum_next[SW-1:2] : cnt_q;
  end

  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (timeout) begin
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (emit) begin
      hist_d[0] = cnt_q;
      for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_next;
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`else
  assign emit_val = cnt_q;
`endif

  assign btn_per_o     = per_q;
  assign btn_per_valid = valid_q;
  assign tp_o          = tick;

endmodule

// File: tb/tb_tap_per_counter.sv
// Bench for tap_per_counter: three instances (default, fast timeout, averaging
// range), table-driven tap gaps with a per-instance expected-result queue.
module tb_tap_per_counter;
  import tap_per_counter_pkg::*;

  localparam int D_CLK = 40,          D_TP = 5120;
  localparam int S_CLK = 200_000_000, S_TP = 10;   // BTN_PER_MAX = 30
  localparam int A_CLK = 1_000_000,   A_TP = 10;   // BTN_PER_MAX = 6000
  localparam int W_D = btn_per_size(D_CLK, D_TP);
  localparam int W_S = btn_per_size(S_CLK, S_TP);
  localparam int W_A = btn_per_size(A_CLK, A_TP);

  typedef struct { int val; int cyc; } exp_t;
  typedef struct { int gap; bit v; int val; } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_v [3];
  logic [W_D-1:0] per_d;
  logic [W_S-1:0] per_s;
  logic [W_A-1:0] per_a;
  logic [31:0] per_v [3];
  logic val_v [3];
  logic tp_v [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_tap [3];
  exp_t sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tap_per_counter #(.CLK_PER_NS(D_CLK), .TP_CYCLE(D_TP)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_v[0]),
    .btn_per_o(per_d), .btn_per_valid(val_v[0]), .tp_o(tp_v[0]));
  tap_per_counter #(.CLK_PER_NS(S_CLK), .TP_CYCLE(S_TP)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_v[1]),
    .btn_per_o(per_s), .btn_per_valid(val_v[1]), .tp_o(tp_v[1]));
  tap_per_counter #(.CLK_PER_NS(A_CLK), .TP_CYCLE(A_TP)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_v[2]),
    .btn_per_o(per_a), .btn_per_valid(val_v[2]), .tp_o(tp_v[2]));

  assign per_v[0] = 32'(per_d);
  assign per_v[1] = 32'(per_s);
  assign per_v[2] = 32'(per_a);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  logic        prev_val [3];
  logic [31:0] prev_per [3];
  int          last_out [3];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n !== 1'b1) begin
        prev_val[i] = 1'b0;
        prev_per[i] = '0;
        last_out[i] = 0;
      end else begin
        if (val_v[i] === 1'b1) begin
          chk($sformatf("pulse_width[%0d]", i), 64'(prev_val[i]), 0);
          chk($sformatf("hold[%0d]", i), 64'(prev_per[i]), 64'(last_out[i]));
          if (sb[i].size() == 0) begin
            chk($sformatf("unexpected_valid[%0d]", i), 64'(val_v[i]), 0);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("period[%0d]", i), 64'(per_v[i]), 64'(e.val));
            chk($sformatf("latency[%0d]", i), 64'(cyc), 64'(e.cyc));
            last_out[i] = e.val;
          end
        end
        prev_val[i] = val_v[i];
        prev_per[i] = per_v[i];
      end
    end
  end

  task automatic tap_now(input int i, input bit exp_v, input int exp_val);
    btn_v[i] = 1'b1;
    if (exp_v) sb[i].push_back('{exp_val, cyc + 1});
    last_tap[i] = cyc;
    @(negedge clk);
    btn_v[i] = 1'b0;
    if (!exp_v) chk($sformatf("arm_no_valid[%0d]", i), 64'(val_v[i]), 0);
  endtask

  task automatic tap(input int i, input int gap, input bit exp_v, input int exp_val);
    while (cyc < last_tap[i] + gap) @(negedge clk);
    tap_now(i, exp_v, exp_val);
  endtask

  vec_t tbl_s [8];
  vec_t tbl_a [5];

  initial begin
    int c1;
    tbl_s[0] = '{100, 1'b1, 10};
    tbl_s[1] = '{299, 1'b1, 29};   // tap lands on the 30th tick: tap wins, no timeout
    tbl_s[2] = '{10,  1'b1, 1};
`ifdef TAP_AVG_EN
    tbl_s[3] = '{9,   1'b1, 10};   // (10+29+1+0)/4
    tbl_s[4] = '{3,   1'b1, 7};    // (29+1+0+0)/4
`else
    tbl_s[3] = '{9,   1'b1, 0};    // tap on the first tick
    tbl_s[4] = '{3,   1'b1, 0};
`endif
    tbl_s[5] = '{300, 1'b0, 0};    // 30th tick times out, this tap only re-arms
    tbl_s[6] = '{57,  1'b1, 5};
    tbl_s[7] = '{30,  1'b1, 3};
`ifdef TAP_AVG_EN
    tbl_a[0] = '{1000, 1'b1, 100};
    tbl_a[1] = '{2000, 1'b1, 200};
    tbl_a[2] = '{3000, 1'b1, 300};
    tbl_a[3] = '{4000, 1'b1, 250};
    tbl_a[4] = '{5000, 1'b1, 350};
`else
    tbl_a[0] = '{1000, 1'b1, 100};
    tbl_a[1] = '{2000, 1'b1, 200};
    tbl_a[2] = '{3000, 1'b1, 300};
    tbl_a[3] = '{4000, 1'b1, 400};
    tbl_a[4] = '{5000, 1'b1, 500};
`endif

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_v[i] = 1'b0;
      last_tap[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_per[%0d]", i), 64'(per_v[i]), 0);
      chk($sformatf("reset_valid[%0d]", i), 64'(val_v[i]), 0);
      chk($sformatf("reset_tp[%0d]", i), 64'(tp_v[i]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default instance: tap on a tick, prescaler realignment, zero period.
    tap_now(0, 1'b0, 0);
    for (int k = 0; k < 2 * D_TP; k++) begin
      if (tp_v[0] === 1'b1) break;
      @(negedge clk);
    end
    chk("tick_phase_after_arm", 64'(cyc - last_tap[0]), 64'(D_TP - 1));
    tap_now(0, 1'b1, 0);
    c1 = last_tap[0];
    while (cyc < c1 + D_TP - 2) @(negedge clk);
    chk("tp_restart_early", 64'(tp_v[0]), 0);
    @(negedge clk);
    chk("tp_restart_tick", 64'(tp_v[0]), 1);
    tap(0, 2 * D_TP, 1'b1, 2);
    tap(0, 3, 1'b1, 0);

    // Small instance: gap table including tick collision and timeout.
    tap_now(1, 1'b0, 0);
    for (int n = 0; n < 8; n++) tap(1, tbl_s[n].gap, tbl_s[n].v, tbl_s[n].val);

    // Held level then release: only the rising edge counts.
    while (cyc < last_tap[1] + 50) @(negedge clk);
    btn_v[1] = 1'b1;
    sb[1].push_back('{5, cyc + 1});
    last_tap[1] = cyc;
    repeat (40) @(negedge clk);
    btn_v[1] = 1'b0;
`ifdef TAP_AVG_EN
    tap(1, 100, 1'b1, 5);          // (5+3+5+10)/4
`else
    tap(1, 100, 1'b1, 10);
`endif

    // Asynchronous reset mid-count, not aligned to either clock edge.
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midreset_per[%0d]", i), 64'(per_v[i]), 0);
      chk($sformatf("midreset_valid[%0d]", i), 64'(val_v[i]), 0);
      chk($sformatf("midreset_tp[%0d]", i), 64'(tp_v[i]), 0);
      chk($sformatf("sb_drained[%0d]", i), 64'(sb[i].size()), 0);
      sb[i].delete();
    end
    #9 rst_n = 1'b1;
    @(negedge clk);
    tap_now(1, 1'b0, 0);
    tap(1, 70, 1'b1, 7);

    // Averaging-range instance.
    tap_now(2, 1'b0, 0);
    for (int n = 0; n < 5; n++) tap(2, tbl_a[n].gap, tbl_a[n].v, tbl_a[n].val);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("sb_empty[%0d]", i), 64'(sb[i].size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
